unified_mem_ctrl: RTL
=====================

# unified_mem_ctrl

Parametrised unified instruction/data memory for the single-cycle CPU: one instruction-fetch read port and one load/store port sharing a word array. Replaces the fixed 1024-word memory with configurable depth, byte-addressed access, byte/half/word stores with sign- or zero-extended loads, alignment and range fault reporting, and a sequenced clear that zeroes one word per cycle behind a Busy flag.

## Interface
- DEPTH, 1024: number of 32-bit words; power of two, 4..65536.
- ADDR_W, 32: byte-address width of ReadPC and RWAddr.
- IDX_W, derived, log2(DEPTH): word-index width.

- Clk  in  1  clock; all state updates on rising edge.
- Clear  in  1  reset, synchronous, active-high; starts a full-array clear sweep.
- ReadPC  in  ADDR_W  fetch byte address.
- RWAddr  in  ADDR_W  load/store byte address.
- Value  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- OP2En  in  1  load/store request valid.
- OP2RW  in  1  1 = store, 0 = load.
- OP2Size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- OP2Signed  in  1  loads: 1 sign-extend, 0 zero-extend.
- Instr  out  32  fetched word, registered.
- Data  out  32  load result, registered, extended to 32 bits.
- Busy  out  1  clear sweep in progress; requests ignored.
- Fault  out  1  registered; previous-cycle request was misaligned, out of range, or reserved size.

## Operation
- Word index = addr[IDX_W+1:2]; byte lane = addr[1:0]. Address is out of range when any addr bit above IDX_W+1 is set.
- States: CLEAR, READY. Clear high at any edge (either state) -> CLEAR, sweep counter = 0, Instr/Data/Fault = 0, Busy = 1.
- CLEAR with Clear low: each edge writes 0 to mem[cnt], cnt++; the edge writing DEPTH-1 moves to READY and drops Busy. Instr/Data hold 0; Fault stays 0; OP2En and ReadPC ignored.
- READY fetch: every edge Instr <= mem[ReadPC index]. ReadPC out of range or ReadPC[1:0] != 0 -> Instr <= 0, Fault <= 1.
- READY store (OP2En=1, OP2RW=1): write enabled only on the lanes selected by size and lane; other lanes are unchanged. Data holds its previous value.
- READY load (OP2En=1, OP2RW=0): Data <= selected byte/half/word, extended per OP2Signed.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0. A misaligned, out-of-range or reserved-size request performs no write, leaves Data unchanged, sets Fault for one cycle.
- Fault <= 1 if either port faults in a cycle, else 0. OP2En=0 contributes no fault.
- Same-cycle store and fetch to the same word: write-first; Instr shows the merged new word.

## Timing
- Read latency 1 cycle on both ports: address presented before edge k, data valid after edge k.
- Store is visible to any read launched in the same cycle (write-first) and to all later reads.
- Clear sweep: Busy high from the edge sampling Clear until DEPTH edges after Clear falls. The first request is accepted at the first edge with Busy low.
- Clear held high: counter stays 0, nothing written; sweep restarts whenever Clear is reasserted mid-sweep.
- Reset values: Instr=0, Data=0, Fault=0, Busy=1, state=CLEAR, cnt=0.

## Structure
- Package mem_pkg: OP2Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum {CLEAR, READY}, fault-check function.
- Sub-module mem_align (combinational): takes size, lane and Value; produces the 4-bit lane write mask, the shifted write word and the load extraction/extension. Top level holds the array, FSM, counter and output registers.

## Test plan
- Clear high 1 cycle, DEPTH=16 -> Busy high for 17 edges including the Clear edge; afterwards a load from every word returns 0.
- Store word 0xDEADBEEF @0x8, then byte store 0x11 @0x9 -> word load @0x8 returns 0xDEAD11EF; signed byte load @0xB returns 0xFFFFFFDE; unsigned byte load @0xB returns 0x000000DE.
- Signed half load @0xA -> 0xFFFFDEAD; half store @0x9 -> Fault=1 next cycle and word @0x8 unchanged.
- Store 0x12345678 @0x4 with ReadPC=0x4 in the same cycle -> Instr=0x12345678 after that edge.
- DEPTH=16, load @0x40 -> Fault=1, Data unchanged. Store with OP2Size=11 -> Fault=1, no write.
- Clear reasserted mid-sweep at cnt=7 with word 12 previously written -> sweep restarts at 0, Busy high for DEPTH more edges, word 12 reads 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and the access fault rule for the unified instruction/data memory.
package mem_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned LANES  = 4;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } op_size_e;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_e;

   // Fault when the address is out of range, misaligned for its size, or the size is reserved.
   function automatic logic access_fault(input op_size_e size, input logic [1:0] lane,
                                         input logic out_of_range);
      logic misaligned;
      case (size)
         SZ_BYTE: misaligned = 1'b0;
         SZ_HALF: misaligned = lane[0];
         SZ_WORD: misaligned = |lane;
         default: misaligned = 1'b1;
      endcase
      return out_of_range | misaligned;
   endfunction

endpackage

// File: rtl/unified_mem_ctrl_if.sv
// Fetch and load/store port bundle between the CPU (master) and the unified memory (slave).
interface unified_mem_ctrl_if #(
   parameter int unsigned ADDR_W = 32
);
   logic [ADDR_W-1:0] ReadPC;
   logic [ADDR_W-1:0] RWAddr;
   logic [31:0]       Value;
   logic              OP2En;
   logic              OP2RW;
   logic [1:0]        OP2Size;
   logic              OP2Signed;
   logic [31:0]       Instr;
   logic [31:0]       Data;
   logic              Busy;
   logic              Fault;

   modport master (
      output ReadPC, RWAddr, Value, OP2En, OP2RW, OP2Size, OP2Signed,
      input  Instr, Data, Busy, Fault
   );

   modport slave (
      input  ReadPC, RWAddr, Value, OP2En, OP2RW, OP2Size, OP2Signed,
      output Instr, Data, Busy, Fault
   );
endinterface

// File: rtl/mem_align.sv
// Lane steering for the load/store port: write mask and replicated store data,
// plus byte/half/word extraction with sign or zero extension for loads.
module mem_align
   import mem_pkg::*;
(
   input  op_size_e    size,
   input  logic [1:0]  lane,
   input  logic        is_signed,
   input  logic [31:0] wr_value,
   input  logic [31:0] rd_word,
   output logic [3:0]  wr_mask_c,
   output logic [31:0] wr_word_c,
   output logic [31:0] rd_data_c
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   assign rd_byte = rd_word[{lane, 3'b000} +: 8];
   assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

   // Store data is replicated across lanes so the mask alone selects the target bytes.
   always_comb begin
      wr_mask_c = 4'b0000;
      wr_word_c = wr_value;
      rd_data_c = rd_word;
      case (size)
         SZ_BYTE: begin
            wr_mask_c = 4'b0001 << lane;
            wr_word_c = {4{wr_value[7:0]}};
            rd_data_c = {{24{is_signed & rd_byte[7]}}, rd_byte};
         end
         SZ_HALF: begin
            wr_mask_c = lane[1] ? 4'b1100 : 4'b0011;
            wr_word_c = {2{wr_value[15:0]}};
            rd_data_c = {{16{is_signed & rd_half[15]}}, rd_half};
         end
         SZ_WORD: begin
            wr_mask_c = 4'b1111;
         end
         default: begin
            rd_data_c = '0;
         end
      endcase
   end

endmodule

// File: rtl/unified_mem_ctrl.sv
// Unified instruction/data memory: one fetch port, one load/store port, byte-lane
// stores, extended loads, fault reporting and a one-word-per-cycle clear sweep.
module unified_mem_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned ADDR_W = 32
) (
   input logic               Clk,
   input logic               Clear,
   unified_mem_ctrl_if.slave bus
);

   localparam int unsigned      IDX_W    = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   logic [WORD_W-1:0] mem_q [DEPTH];

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              fault_q, fault_d;
   logic [WORD_W-1:0] instr_q, instr_d;
   logic [WORD_W-1:0] data_q, data_d;

   logic              mem_we;
   logic [IDX_W-1:0]  mem_waddr;
   logic [WORD_W-1:0] mem_wdata;

   logic [IDX_W-1:0]  pc_idx, rw_idx;
   logic              pc_oor, rw_oor;
   logic              pc_fault, op_fault;
   logic              store_ok, load_ok;
   op_size_e          op_size;
   logic [WORD_W-1:0] pc_word, rw_word, merged_word;
   logic [LANES-1:0]  wr_mask;
   logic [WORD_W-1:0] wr_word, ld_data;

   assign op_size = op_size_e'(bus.OP2Size);
   assign pc_idx  = bus.ReadPC[IDX_W+1:2];
   assign rw_idx  = bus.RWAddr[IDX_W+1:2];
   assign pc_oor  = |(bus.ReadPC >> (IDX_W + 2));
   assign rw_oor  = |(bus.RWAddr >> (IDX_W + 2));

   // A fetch is always a word access; the load/store port only faults when requesting.
   assign pc_fault = access_fault(SZ_WORD, bus.ReadPC[1:0], pc_oor);
   assign op_fault = bus.OP2En & access_fault(op_size, bus.RWAddr[1:0], rw_oor);
   assign store_ok = bus.OP2En & bus.OP2RW & ~op_fault;
   assign load_ok  = bus.OP2En & ~bus.OP2RW & ~op_fault;

   assign pc_word = mem_q[pc_idx];
   assign rw_word = mem_q[rw_idx];

   mem_align u_align (
      .size      (op_size),
      .lane      (bus.RWAddr[1:0]),
      .is_signed (bus.OP2Signed),
      .wr_value  (bus.Value),
      .rd_word   (rw_word),
      .wr_mask_c (wr_mask),
      .wr_word_c (wr_word),
      .rd_data_c (ld_data)
   );

   // Byte-lane merge of the store into the current word.
   always_comb begin
      merged_word = rw_word;
      for (int i = 0; i < int'(LANES); i++) begin
         if (wr_mask[i]) begin
            merged_word[8*i +: 8] = wr_word[8*i +: 8];
         end
      end
   end

   // Next-state, memory write port and output register inputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      instr_d   = instr_q;
      data_d    = data_q;
      fault_d   = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = cnt_q;
      mem_wdata = '0;
      case (state_q)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
            cnt_d     = cnt_q + IDX_W'(1);
            instr_d   = '0;
            data_d    = '0;
            if (cnt_q == LAST_IDX) begin
               state_d = READY;
               busy_d  = 1'b0;
            end
         end
         READY: begin
            busy_d = 1'b0;
            if (store_ok) begin
               mem_we    = 1'b1;
               mem_waddr = rw_idx;
               mem_wdata = merged_word;
            end
            if (load_ok) begin
               data_d = ld_data;
            end
            // Write-first: a same-cycle store to the fetched word is visible on Instr.
            if (pc_fault) begin
               instr_d = '0;
            end else if (store_ok && (rw_idx == pc_idx)) begin
               instr_d = merged_word;
            end else begin
               instr_d = pc_word;
            end
            fault_d = pc_fault | op_fault;
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Clear && mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge Clk) begin
      if (Clear) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
         instr_q <= '0;
         data_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         instr_q <= instr_d;
         data_q  <= data_d;
         fault_q <= fault_d;
      end
   end

   assign bus.Instr = instr_q;
   assign bus.Data  = data_q;
   assign bus.Busy  = busy_q;
   assign bus.Fault = fault_q;

endmodule
